// File: rtl/sao_filter_if.sv
`default_nettype none
// ============================================================================
// Module   : sao_filter_if
// Purpose  : Pixel stream, per-LCU SAO parameters and status for sao_filter.
// Revision : 1.0 - initial release
// ============================================================================
interface sao_filter_if;
    logic        in_en;
    logic [7:0]  din;
    logic [1:0]  sao_type;
    logic [4:0]  sao_band_pos;
    logic        sao_eo_class;
    logic [15:0] sao_offset;
    logic [2:0]  lcu_x;
    logic [2:0]  lcu_y;
    logic [1:0]  lcu_size;
    logic        busy;
    logic        finish;

    modport master (
        output in_en, din, sao_type, sao_band_pos, sao_eo_class, sao_offset,
               lcu_x, lcu_y, lcu_size,
        input  busy, finish
    );

    modport slave (
        input  in_en, din, sao_type, sao_band_pos, sao_eo_class, sao_offset,
               lcu_x, lcu_y, lcu_size,
        output busy, finish
    );
endinterface
`default_nettype wire

// File: rtl/sao_filter.sv
`default_nettype none
// ============================================================================
// Module   : sao_filter
// Purpose  : SAO post-filter (off / band / edge offset) for a square 8-bit luma
//            image; LCUs ping-pong through two buffers into a frame SRAM.
//            Optional feature macro: SAO_CLIP_EN (saturate results to 0..255).
// Revision : 1.0 - initial release
// ============================================================================
module sao_frame_sram #(
    parameter int DEPTH = 16384,
    parameter int AW    = 14
) (
    input  wire logic          clk,
    input  wire logic          we,
    input  wire logic [AW-1:0] addr,
    input  wire logic [7:0]    wdata
);
    logic [7:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end
endmodule

module sao_filter #(
    parameter int IMG_W   = 128,
    parameter int MAX_LCU = 64
) (
    input  wire logic   clk,
    input  wire logic   reset,
    sao_filter_if.slave bus
);
    localparam int PIX_TOTAL = IMG_W * IMG_W;
    localparam int AW        = $clog2(PIX_TOTAL);
    localparam int CNT_W     = AW + 1;
    localparam int BUF_DEPTH = MAX_LCU * MAX_LCU;
    localparam int IDX_W     = $clog2(BUF_DEPTH);
    localparam int COORD_W   = $clog2(IMG_W);

    typedef struct packed {
        logic [1:0]  sao_type;
        logic [4:0]  band_pos;
        logic        eo_class;
        logic [15:0] offset;
        logic [2:0]  lcu_x;
        logic [2:0]  lcu_y;
    } sao_par_t;

    // Receive side
    logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
    logic [IDX_W-1:0]   widx_q, widx_d;
    logic               wsel_q, wsel_d;
    // Drain side
    logic [IDX_W-1:0]   ridx_q, ridx_d;
    logic               rsel_q, rsel_d;
    logic [1:0]         full_q, full_d;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic               finish_q, finish_d;

    logic [7:0]         lcu_buf_q [0:2*BUF_DEPTH-1];
    sao_par_t           par_q [2];

    logic [2:0]         n_log;
    logic [IDX_W-1:0]   lcu_last;
    logic [COORD_W-1:0] lcu_n;
    logic               accept, wr_last, drain, rd_last;
    sao_par_t           par_in, cur;

    always_comb begin
        n_log    = 3'd4;
        lcu_last = IDX_W'(255);
        case (bus.lcu_size)
            2'd1: begin
                n_log    = 3'd5;
                lcu_last = IDX_W'(1023);
            end
            2'd2: begin
                n_log    = 3'd6;
                lcu_last = IDX_W'(4095);
            end
            default: ;
        endcase
        lcu_n = COORD_W'(1) << n_log;
    end

    always_comb begin
        par_in.sao_type = bus.sao_type;
        par_in.band_pos = bus.sao_band_pos;
        par_in.eo_class = bus.sao_eo_class;
        par_in.offset   = bus.sao_offset;
        par_in.lcu_x    = bus.lcu_x;
        par_in.lcu_y    = bus.lcu_y;
    end

    // Drain keeps pace with receive, so a buffer is always free when a new LCU starts.
    always_comb begin
        accept   = !reset && bus.in_en && (in_cnt_q < CNT_W'(PIX_TOTAL));
        wr_last  = accept && (widx_q == lcu_last);
        in_cnt_d = accept ? in_cnt_q + CNT_W'(1) : in_cnt_q;
        widx_d   = accept ? (wr_last ? '0 : widx_q + IDX_W'(1)) : widx_q;
        wsel_d   = wr_last ? ~wsel_q : wsel_q;

        drain    = !reset && full_q[rsel_q];
        rd_last  = drain && (ridx_q == lcu_last);
        ridx_d   = drain ? (rd_last ? '0 : ridx_q + IDX_W'(1)) : ridx_q;
        rsel_d   = rd_last ? ~rsel_q : rsel_q;
        wr_cnt_d = drain ? wr_cnt_q + CNT_W'(1) : wr_cnt_q;
        finish_d = finish_q || (drain && (wr_cnt_q == CNT_W'(PIX_TOTAL - 1)));

        full_d = full_q;
        if (wr_last) begin
            full_d[wsel_q] = 1'b1;
        end
        if (rd_last) begin
            full_d[rsel_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_cnt_q <= '0;
            widx_q   <= '0;
            wsel_q   <= 1'b0;
            ridx_q   <= '0;
            rsel_q   <= 1'b0;
            full_q   <= '0;
            wr_cnt_q <= '0;
            finish_q <= 1'b0;
        end else begin
            in_cnt_q <= in_cnt_d;
            widx_q   <= widx_d;
            wsel_q   <= wsel_d;
            ridx_q   <= ridx_d;
            rsel_q   <= rsel_d;
            full_q   <= full_d;
            wr_cnt_q <= wr_cnt_d;
            finish_q <= finish_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lcu_buf_q[{wsel_q, widx_q}] <= bus.din;
            if (widx_q == '0) begin
                par_q[wsel_q] <= par_in;
            end
        end
    end

    // Drain datapath: current pixel, its two EO neighbours and the filtered result
    logic [COORD_W-1:0] in_r, in_c, frame_r, frame_c;
    logic [IDX_W-1:0]   step, a_idx, b_idx;
    logic [7:0]         pix_p, pix_a, pix_b, pix_out, filt;
    logic               eo_edge, apply;
    logic [2:0]         eo_cat;
    logic [4:0]         band_k;
    logic [1:0]         off_sel;
    logic [3:0]         off4;
    logic [AW-1:0]      sram_addr;
`ifdef SAO_CLIP_EN
    logic [9:0]         sum;
`else
    logic [7:0]         sum;
`endif

    always_comb begin
        cur     = par_q[rsel_q];
        in_r    = COORD_W'(ridx_q >> n_log);
        in_c    = COORD_W'(ridx_q) & (lcu_n - COORD_W'(1));
        step    = cur.eo_class ? IDX_W'(lcu_n) : IDX_W'(1);
        a_idx   = ridx_q - step;
        b_idx   = ridx_q + step;
        pix_p   = lcu_buf_q[{rsel_q, ridx_q}];
        pix_a   = lcu_buf_q[{rsel_q, a_idx}];
        pix_b   = lcu_buf_q[{rsel_q, b_idx}];
        eo_edge = cur.eo_class ? ((in_r == '0) || (in_r == lcu_n - COORD_W'(1)))
                               : ((in_c == '0) || (in_c == lcu_n - COORD_W'(1)));

        if ((pix_p < pix_a) && (pix_p < pix_b)) begin
            eo_cat = 3'd1;
        end else if (((pix_p < pix_a) && (pix_p == pix_b)) || ((pix_p == pix_a) && (pix_p < pix_b))) begin
            eo_cat = 3'd2;
        end else if (((pix_p > pix_a) && (pix_p == pix_b)) || ((pix_p == pix_a) && (pix_p > pix_b))) begin
            eo_cat = 3'd3;
        end else if ((pix_p > pix_a) && (pix_p > pix_b)) begin
            eo_cat = 3'd4;
        end else begin
            eo_cat = 3'd0;
        end

        band_k  = pix_p[7:3] - cur.band_pos;
        apply   = 1'b0;
        off_sel = 2'd0;
        case (cur.sao_type)
            2'd1: begin
                if ((pix_p[7:3] >= cur.band_pos) && (band_k < 5'd4)) begin
                    apply   = 1'b1;
                    off_sel = band_k[1:0];
                end
            end
            2'd2: begin
                if (!eo_edge && (eo_cat != 3'd0)) begin
                    apply   = 1'b1;
                    off_sel = 2'(eo_cat - 3'd1);
                end
            end
            default: ;
        endcase

        case (off_sel)
            2'd0:    off4 = cur.offset[15:12];
            2'd1:    off4 = cur.offset[11:8];
            2'd2:    off4 = cur.offset[7:4];
            default: off4 = cur.offset[3:0];
        endcase

`ifdef SAO_CLIP_EN
        // 10-bit two's complement: bit 9 flags underflow, bit 8 overflow.
        sum  = {2'b00, pix_p} + {{6{off4[3]}}, off4};
        filt = sum[9] ? 8'd0 : (sum[8] ? 8'd255 : sum[7:0]);
`else
        sum  = pix_p + {{4{off4[3]}}, off4};
        filt = sum;
`endif
        pix_out = apply ? filt : pix_p;

        frame_r   = (COORD_W'(cur.lcu_y) << n_log) + in_r;
        frame_c   = (COORD_W'(cur.lcu_x) << n_log) + in_c;
        sram_addr = {frame_r, frame_c};
    end

    sao_frame_sram #(
        .DEPTH (PIX_TOTAL),
        .AW    (AW)
    ) golden_sram (
        .clk   (clk),
        .we    (drain),
        .addr  (sram_addr),
        .wdata (pix_out)
    );

    assign bus.busy   = 1'b0;
    assign bus.finish = finish_q;
endmodule
`default_nettype wire

// File: tb/tb_sao_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sao_filter
// Purpose  : Directed + randomized bench for sao_filter against a frame-level
//            reference model of the SAO rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sao_filter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sao_filter_if bus ();

    sao_filter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    bit busy_seen = 1'b0;

    logic [7:0]  img_in  [0:16383];
    logic [7:0]  exp_img [0:16383];
    logic [1:0]  p_type  [0:63];
    logic [4:0]  p_band  [0:63];
    logic        p_eo    [0:63];
    logic [15:0] p_off   [0:63];
    int          lcu_n;

    always @(negedge clk) if (bus.busy !== 1'b0) busy_seen = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] size_code(input int n);
        return (n == 64) ? 2'd2 : (n == 32) ? 2'd1 : 2'd0;
    endfunction

    // Expected output of one frame pixel, computed in frame coordinates.
    function automatic logic [7:0] ref_pix(input int row, input int col);
        int n, l, p, a, b, res, cat, k, ri, ci;
        int off [4];
        bit edge_px;
        n  = lcu_n;
        l  = (row / n) * 8 + (col / n);
        ri = row % n;
        ci = col % n;
        p  = int'(img_in[row*128 + col]);
        for (int i = 0; i < 4; i++) begin
            off[i] = int'(p_off[l][15-4*i -: 4]);
            if (off[i] > 7) off[i] -= 16;
        end
        res = p;
        if (p_type[l] == 2'd1) begin
            k = (p / 8) - int'(p_band[l]);
            if (k >= 0 && k <= 3) res = p + off[k];
        end else if (p_type[l] == 2'd2) begin
            a = 0;
            b = 0;
            if (p_eo[l] == 1'b0) begin
                edge_px = (ci == 0) || (ci == n - 1);
                if (!edge_px) begin
                    a = int'(img_in[row*128 + col - 1]);
                    b = int'(img_in[row*128 + col + 1]);
                end
            end else begin
                edge_px = (ri == 0) || (ri == n - 1);
                if (!edge_px) begin
                    a = int'(img_in[(row-1)*128 + col]);
                    b = int'(img_in[(row+1)*128 + col]);
                end
            end
            cat = 0;
            if (!edge_px) begin
                if (p < a && p < b) cat = 1;
                else if ((p < a && p == b) || (p == a && p < b)) cat = 2;
                else if ((p > a && p == b) || (p == a && p > b)) cat = 3;
                else if (p > a && p > b) cat = 4;
            end
            if (cat > 0) res = p + off[cat-1];
        end
`ifdef SAO_CLIP_EN
        if (res < 0) res = 0;
        if (res > 255) res = 255;
`endif
        return 8'(res);
    endfunction

    function automatic logic [7:0] rnd_pix();
        case ($urandom_range(3))
            0:       return 8'($urandom_range(255));
            1:       return 8'(120 + $urandom_range(2));
            2:       return ($urandom_range(1) == 1) ? 8'($urandom_range(7)) : 8'(248 + $urandom_range(7));
            default: return 8'(60 + $urandom_range(5));
        endcase
    endfunction

    task automatic gen_random(input int n);
        lcu_n = n;
        for (int l = 0; l < 64; l++) begin
            p_type[l] = 2'($urandom_range(3));
            p_band[l] = 5'($urandom_range(31));
            p_eo[l]   = 1'($urandom_range(1));
            p_off[l]  = 16'($urandom);
        end
        for (int a = 0; a < 16384; a++) img_in[a] = rnd_pix();
    endtask

    task automatic set_par(input int l, input int t, input int band, input int eo, input logic [15:0] off);
        p_type[l] = 2'(t);
        p_band[l] = 5'(band);
        p_eo[l]   = 1'(eo);
        p_off[l]  = off;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        bus.in_en = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Streams LCUs in raster order; only the first pixel of each LCU carries
    // its real parameters when scramble is set.
    task automatic send_image(input int limit, input bit gaps, input bit scramble);
        int sent = 0;
        int nl   = 128 / lcu_n;
        bus.lcu_size = size_code(lcu_n);
        for (int ly = 0; ly < nl; ly++)
            for (int lx = 0; lx < nl; lx++)
                for (int r = 0; r < lcu_n; r++)
                    for (int c = 0; c < lcu_n; c++) begin
                        if (sent < limit) begin
                            if (gaps && $urandom_range(15) == 0) begin
                                bus.in_en = 1'b0;
                                bus.din   = 8'($urandom);
                                @(negedge clk);
                            end
                            bus.in_en = 1'b1;
                            bus.din   = img_in[(ly*lcu_n + r)*128 + lx*lcu_n + c];
                            if ((r == 0 && c == 0) || !scramble) begin
                                bus.sao_type     = p_type[ly*8 + lx];
                                bus.sao_band_pos = p_band[ly*8 + lx];
                                bus.sao_eo_class = p_eo[ly*8 + lx];
                                bus.sao_offset   = p_off[ly*8 + lx];
                                bus.lcu_x        = 3'(lx);
                                bus.lcu_y        = 3'(ly);
                            end else begin
                                bus.sao_type     = 2'($urandom);
                                bus.sao_band_pos = 5'($urandom);
                                bus.sao_eo_class = 1'($urandom);
                                bus.sao_offset   = 16'($urandom);
                                bus.lcu_x        = 3'($urandom);
                                bus.lcu_y        = 3'($urandom);
                            end
                            @(negedge clk);
                            sent++;
                        end
                    end
        bus.in_en = 1'b0;
    endtask

    task automatic check_image(input string tag);
        int bad   = 0;
        int first = -1;
        for (int a = 0; a < 16384; a++) begin
            if (dut.golden_sram.mem[a] !== exp_img[a]) begin
                if (first < 0) first = a;
                bad++;
            end
        end
        chk($sformatf("%s_mismatch_count first_bad_addr=%0d", tag, first), bad, 0);
    endtask

    task automatic run_image(input string tag, input bit gaps, input bit scramble);
        int cyc = 0;
        for (int row = 0; row < 128; row++)
            for (int col = 0; col < 128; col++)
                exp_img[row*128 + col] = ref_pix(row, col);
        send_image(16384, gaps, scramble);
        chk({tag, "_finish_early"}, {31'd0, bus.finish}, 0);
        while (bus.finish !== 1'b1 && cyc < lcu_n*lcu_n + 4) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_finish_within_bound"}, {31'd0, bus.finish}, 1);
        check_image(tag);
    endtask

    function automatic logic [31:0] mem_at(input int a);
        return {24'd0, dut.golden_sram.mem[a]};
    endfunction

    initial begin
        reset            = 1'b1;
        bus.in_en        = 1'b0;
        bus.din          = '0;
        bus.sao_type     = '0;
        bus.sao_band_pos = '0;
        bus.sao_eo_class = 1'b0;
        bus.sao_offset   = '0;
        bus.lcu_x        = '0;
        bus.lcu_y        = '0;
        bus.lcu_size     = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, bus.busy}, 0);
        chk("reset_finish", {31'd0, bus.finish}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_finish", {31'd0, bus.finish}, 0);

        // Pass-through ramp image, 16x16 LCUs
        gen_random(16);
        for (int l = 0; l < 64; l++) p_type[l] = 2'd0;
        for (int a = 0; a < 16384; a++) img_in[a] = 8'(a);
        run_image("ramp", 1'b0, 1'b0);
        chk("ramp_addr_300", mem_at(300), 300 % 256);
        bus.lcu_size = 2'd0;
        for (int i = 0; i < 64; i++) begin
            bus.in_en = 1'b1;
            bus.din   = 8'($urandom);
            @(negedge clk);
        end
        bus.in_en = 1'b0;
        repeat (4) @(negedge clk);
        chk("extra_pixels_finish_held", {31'd0, bus.finish}, 1);
        check_image("extra_pixels_ignored");
        do_reset();
        chk("rearm_finish", {31'd0, bus.finish}, 0);

        // Directed BO / EO / off / saturation cases, 16x16 LCUs
        gen_random(16);
        set_par(0, 1, 4, 0, 16'h12D7);
        img_in[0] = 8'd40; img_in[1] = 8'd31; img_in[2] = 8'd64; img_in[3] = 8'd39; img_in[4] = 8'd63;
        set_par(1, 2, 0, 0, 16'h31FC);
        for (int c = 0; c < 16; c++) img_in[16 + c] = (c % 2 == 1) ? 8'd20 : 8'd10;
        img_in[144] = 8'd30; img_in[145] = 8'd30; img_in[146] = 8'd40; img_in[147] = 8'd40; img_in[148] = 8'd35;
        set_par(2, 2, 0, 1, 16'h21FD);
        img_in[37] = 8'd50; img_in[165] = 8'd60; img_in[293] = 8'd50; img_in[1829] = 8'd200; img_in[1957] = 8'd0;
        set_par(3, 3, 0, 0, 16'h7777);
        img_in[48] = 8'd77;
        set_par(4, 1, 28, 0, 16'h0007);
        img_in[64] = 8'd254;
        set_par(5, 1, 0, 0, 16'h8000);
        img_in[80] = 8'd2;
        run_image("directed", 1'b1, 1'b1);
        chk("bo_band5", mem_at(0), 42);
        chk("bo_band3_outside", mem_at(1), 31);
        chk("bo_band8_outside", mem_at(2), 64);
        chk("bo_k0", mem_at(3), 40);
        chk("bo_k3", mem_at(4), 70);
        chk("eo_h_col0", mem_at(16), 10);
        chk("eo_h_cat4", mem_at(17), 16);
        chk("eo_h_cat1", mem_at(18), 13);
        chk("eo_h_col15", mem_at(31), 20);
        chk("eo_h_cat2", mem_at(145), 31);
        chk("eo_h_cat3_eqb", mem_at(146), 39);
        chk("eo_h_cat3_eqa", mem_at(147), 39);
        chk("eo_v_row0", mem_at(37), 50);
        chk("eo_v_cat4", mem_at(165), 57);
        chk("eo_v_row15", mem_at(1957), 0);
        chk("type3_off", mem_at(48), 77);
`ifdef SAO_CLIP_EN
        chk("bo_sat_high", mem_at(64), 255);
        chk("bo_sat_low", mem_at(80), 0);
`else
        chk("bo_wrap_high", mem_at(64), 5);
        chk("bo_wrap_low", mem_at(80), 250);
`endif
        do_reset();

        // Random 32x32 LCUs with a vertical valley and LCU(3,2) origin probe
        gen_random(32);
        set_par(0, 2, 0, 1, 16'h21FD);
        img_in[3] = 8'd50; img_in[131] = 8'd60; img_in[259] = 8'd50;
        set_par(19, 0, 0, 0, 16'h0000);
        img_in[8288] = 8'd165;
        run_image("lcu32", 1'b1, 1'b1);
        chk("lcu32_v_row0", mem_at(3), 50);
        chk("lcu32_v_cat4", mem_at(131), 57);
        chk("lcu32_x3_y2_origin", mem_at(8288), 165);
        do_reset();

        // Abort after 1000 pixels, then a fresh 64x64-LCU image
        gen_random(16);
        send_image(1000, 1'b0, 1'b1);
        do_reset();
        chk("abort_finish", {31'd0, bus.finish}, 0);
        repeat (lcu_n * lcu_n + 8) @(negedge clk);
        chk("abort_no_finish", {31'd0, bus.finish}, 0);
        gen_random(64);
        run_image("after_abort_lcu64", 1'b1, 1'b1);

        chk("busy_never_high", {31'd0, busy_seen}, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
